// File: rtl/mem_arbiter.sv
// Purpose : shares one single-port byte-enable RAM between instruction fetch and data load/store.
// Latency : grant and RAM drive are combinational; read data returns RD_LAT cycles after acceptance.
// Backpressure: an ungranted requester holds req/addr/data until gnt; data wins conflicts except on fetch starvation.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   if_req/if_addr            fetch read request, byte address
//   if_gnt/if_rvalid/if_rdata fetch accept strobe, read return
//   d_req/d_we/d_addr/d_wdata data request (d_we == 0 means read)
//   d_gnt/d_rvalid/d_rdata    data accept strobe, read return
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  RAM interface (word address)
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_D    = 2'd2
    } tag_e;

    logic [SW-1:0] r_starve;
    tag_e          r_tag [RD_LAT];
    logic [31:0]   r_if_hold;
    logic [31:0]   r_d_hold;

    logic          w_starved;
    logic          w_d_sel;
    logic          w_if_sel;
    tag_e          w_tag_push;
    tag_e          w_tag_out;
    logic          w_unused;

    // Fetch only overrides data once it has lost STARVE_MAX conflicts in a row.
    assign w_starved = (STARVE_MAX != 0) && (r_starve == STARVE_TOP);
    assign w_d_sel   = d_req && !(if_req && w_starved);
    assign w_if_sel  = if_req && !w_d_sel;

    // Gating with rst makes grants and the RAM drive drop the instant reset asserts.
    assign d_gnt     = rst && w_d_sel;
    assign if_gnt    = rst && w_if_sel;
    assign mem_en    = d_gnt || if_gnt;
    assign mem_we    = d_gnt ? d_we : 4'b0000;
    assign mem_addr  = d_gnt  ? d_addr[ADDR_W+1:2] :
                       if_gnt ? if_addr[ADDR_W+1:2] : '0;
    assign mem_wdata = rst ? d_wdata : 32'd0;

    // Byte offset and bits above the RAM window are deliberately dropped (address aliasing).
    assign w_unused  = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

    always_comb begin
        w_tag_push = TAG_NONE;
        if (if_gnt) begin
            w_tag_push = TAG_IF;
        end else if (d_gnt && (d_we == 4'b0000)) begin
            w_tag_push = TAG_D;
        end
    end

    // Owner tags travel alongside the RAM read pipeline so each return finds its requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= TAG_NONE;
            end
        end else begin
            r_tag[0] <= w_tag_push;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_tag_out = r_tag[RD_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (if_gnt) begin
            r_starve <= '0;
        end else if (if_req && d_gnt && (r_starve != STARVE_TOP)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Each side keeps its last returned word while the RAM serves the other side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_hold <= 32'd0;
            r_d_hold  <= 32'd0;
        end else begin
            if (w_tag_out == TAG_IF) begin
                r_if_hold <= mem_rdata;
            end
            if (w_tag_out == TAG_D) begin
                r_d_hold <= mem_rdata;
            end
        end
    end

    assign if_rvalid = (w_tag_out == TAG_IF);
    assign d_rvalid  = (w_tag_out == TAG_D);
    assign if_rdata  = if_rvalid ? mem_rdata : r_if_hold;
    assign d_rdata   = d_rvalid  ? mem_rdata : r_d_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed bench for mem_arbiter; two instances (RD_LAT=1 and RD_LAT=2) share one stimulus.
// Latency : read returns are scored against a queue of expected {owner, data, due cycle} entries.
// Backpressure: expected grants are stated per step; ungranted requests push nothing.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic [1:0]  if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en;
    logic [31:0] if_rdata  [2];
    logic [31:0] d_rdata   [2];
    logic [3:0]  mem_we    [2];
    logic [9:0]  mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    typedef struct {
        bit          is_if;
        logic [31:0] dat;
        int          due;
    } rd_t;

    rd_t         q [2][$];
    logic [31:0] last_if [2];
    logic [31:0] last_d  [2];
    logic [31:0] model   [1024];
    logic [31:0] ram     [2][1024];
    logic [31:0] rd_a    [2];
    logic [31:0] rd_b    [2];
    bit          ram_init = 1'b0;
    bit          started  = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_arbiter #(.ADDR_W(10), .RD_LAT(1), .STARVE_MAX(3)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_arbiter #(.ADDR_W(10), .RD_LAT(2), .STARVE_MAX(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic logic [31:0] init_word(input int j);
        return 32'hA500_0000 ^ (j * 32'h0001_0203);
    endfunction

    // Behavioural RAMs: byte-enable write, synchronous read, one or two output stages.
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int j = 0; j < 1024; j++) begin
                ram[0][j] <= init_word(j);
                ram[1][j] <= init_word(j);
            end
            ram_init <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mem_en[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_we[i][b]) ram[i][mem_addr[i]][8*b +: 8] <= mem_wdata[i][8*b +: 8];
                    end
                    rd_a[i] <= ram[i][mem_addr[i]];
                end
                rd_b[i] <= rd_a[i];
            end
        end
    end

    assign mem_rdata[0] = rd_a[0];
    assign mem_rdata[1] = rd_b[1];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Read-return scoreboard: compares every cycle, including "no rvalid" and rdata hold.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                bit          ei;
                bit          ed;
                logic [31:0] dv;
                ei = 1'b0;
                ed = 1'b0;
                dv = 32'd0;
                if (q[i].size() > 0 && q[i][0].due == cyc) begin
                    ei = q[i][0].is_if;
                    ed = !q[i][0].is_if;
                    dv = q[i][0].dat;
                    void'(q[i].pop_front());
                end
                chk($sformatf("dut%0d if_rvalid", i), {31'd0, if_rvalid[i]}, {31'd0, ei});
                chk($sformatf("dut%0d d_rvalid", i),  {31'd0, d_rvalid[i]},  {31'd0, ed});
                if (ei) last_if[i] = dv;
                if (ed) last_d[i]  = dv;
                chk($sformatf("dut%0d if_rdata", i), if_rdata[i], last_if[i]);
                chk($sformatf("dut%0d d_rdata", i),  d_rdata[i],  last_d[i]);
            end
        end
    end

    // Called just after a rising edge; who: 0 none, 1 fetch, 2 data. ea is the expected word address.
    task automatic step(input bit ifr, input logic [31:0] ifa, input bit dr, input logic [3:0] dwe,
                        input logic [31:0] da, input logic [31:0] dwd, input int who,
                        input logic [9:0] ea, input string name);
        if_req  = ifr;
        if_addr = ifa;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s dut%0d if_gnt", name, i), {31'd0, if_gnt[i]}, {31'd0, who == 1});
            chk($sformatf("%s dut%0d d_gnt", name, i),  {31'd0, d_gnt[i]},  {31'd0, who == 2});
            chk($sformatf("%s dut%0d mem_en", name, i), {31'd0, mem_en[i]}, {31'd0, who != 0});
            chk($sformatf("%s dut%0d mem_we", name, i), {28'd0, mem_we[i]},
                {28'd0, (who == 2) ? dwe : 4'b0000});
            if (who != 0) chk($sformatf("%s dut%0d mem_addr", name, i), {22'd0, mem_addr[i]}, {22'd0, ea});
            if (who == 2) chk($sformatf("%s dut%0d mem_wdata", name, i), mem_wdata[i], dwd);
            if (who == 1 || (who == 2 && dwe == 4'b0000)) begin
                q[i].push_back('{is_if: (who == 1), dat: model[ea], due: cyc + i + 1});
            end
        end
        if (who == 2) begin
            for (int b = 0; b < 4; b++) begin
                if (dwe[b]) model[ea][8*b +: 8] = dwd[8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0, 10'd0, "idle");
    endtask

    task automatic flush;
        for (int i = 0; i < 2; i++) begin
            q[i].delete();
            last_if[i] = 32'd0;
            last_d[i]  = 32'd0;
        end
    endtask

    initial begin
        logic [7:0] pat;
        for (int j = 0; j < 1024; j++) model[j] = init_word(j);
        flush();
        rst     = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h10;
        d_req   = 1'b1;
        d_we    = 4'hF;
        d_addr  = 32'h20;
        d_wdata = 32'h1234_5678;

        // Everything quiet while reset is held, even with both requests pending.
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst dut%0d if_gnt", i),    {31'd0, if_gnt[i]},    32'd0);
            chk($sformatf("rst dut%0d d_gnt", i),     {31'd0, d_gnt[i]},     32'd0);
            chk($sformatf("rst dut%0d if_rvalid", i), {31'd0, if_rvalid[i]}, 32'd0);
            chk($sformatf("rst dut%0d d_rvalid", i),  {31'd0, d_rvalid[i]},  32'd0);
            chk($sformatf("rst dut%0d if_rdata", i),  if_rdata[i],           32'd0);
            chk($sformatf("rst dut%0d d_rdata", i),   d_rdata[i],            32'd0);
            chk($sformatf("rst dut%0d mem_en", i),    {31'd0, mem_en[i]},    32'd0);
            chk($sformatf("rst dut%0d mem_we", i),    {28'd0, mem_we[i]},    32'd0);
            chk($sformatf("rst dut%0d mem_addr", i),  {22'd0, mem_addr[i]},  32'd0);
            chk($sformatf("rst dut%0d mem_wdata", i), mem_wdata[i],          32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        started = 1'b1;

        // Accept a fetch, then reset before its data returns: the return must never show up.
        step(1'b1, 32'h10, 1'b0, 4'd0, 32'd0, 32'd0, 1, 10'd4, "pre_rst");
        rst = 1'b0;
        flush();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("midrst dut%0d if_gnt", i),    {31'd0, if_gnt[i]},    32'd0);
            chk($sformatf("midrst dut%0d if_rvalid", i), {31'd0, if_rvalid[i]}, 32'd0);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        rst    = 1'b1;
        idle(3);

        // Fetch only, same address three times.
        for (int k = 0; k < 3; k++) step(1'b1, 32'h10, 1'b0, 4'd0, 32'd0, 32'd0, 1, 10'd4, "fetch");
        idle(1);

        // Full-word write, read back, byte write, read back.
        step(1'b0, 32'd0, 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF, 2, 10'd8, "wr_full");
        step(1'b0, 32'd0, 1'b1, 4'h0, 32'h20, 32'd0,         2, 10'd8, "rd_full");
        step(1'b0, 32'd0, 1'b1, 4'h1, 32'h20, 32'h0000_0011, 2, 10'd8, "wr_byte");
        step(1'b0, 32'd0, 1'b1, 4'h0, 32'h20, 32'd0,         2, 10'd8, "rd_byte");
        idle(2);

        // Sustained conflict: fetch wins every fourth cycle (bit 7 is the first cycle).
        pat = 8'b0001_0001;
        for (int k = 0; k < 8; k++) begin
            if (pat[7-k]) step(1'b1, 32'h40, 1'b1, 4'd0, 32'h44, 32'd0, 1, 10'd16, "conflict");
            else          step(1'b1, 32'h40, 1'b1, 4'd0, 32'h44, 32'd0, 2, 10'd17, "conflict");
        end
        idle(2);

        // Alternating owners back to back.
        step(1'b1, 32'h0, 1'b0, 4'd0, 32'h0, 32'd0, 1, 10'd0, "ilv_if0");
        step(1'b0, 32'h0, 1'b1, 4'd0, 32'h4, 32'd0, 2, 10'd1, "ilv_d1");
        step(1'b1, 32'h8, 1'b0, 4'd0, 32'h0, 32'd0, 1, 10'd2, "ilv_if2");
        idle(3);

        // Address aliasing for both requesters.
        step(1'b0, 32'h0,         1'b1, 4'd0, 32'h0000_1004, 32'd0, 2, 10'd1, "alias_d");
        step(1'b1, 32'hFFFF_F00B, 1'b0, 4'd0, 32'h0,         32'd0, 1, 10'd2, "alias_if");
        idle(4);

        for (int i = 0; i < 2; i++) chk($sformatf("dut%0d pending_reads", i), q[i].size(), 32'd0);
        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
